// File: rtl/draw_seq_pkg.sv
// Shared types and default sizing for the Gold Miner render sequencer.
package draw_seq_pkg;

  localparam int STATE_W         = 4;
  localparam int DEF_NUM_CLASSES = 3;
  localparam int DEF_IDX_W       = 5;
  localparam int DEF_FRAME_DIV   = 833334;
  localparam int DEF_TIMEOUT     = 65535;

  typedef enum logic [STATE_W-1:0] {
    S_START,
    S_SPLASH,
    S_SPLASH_WAIT,
    S_GEN_XY,
    S_BG,
    S_OBJ_SEL,
    S_OBJ,
    S_HOOK,
    S_NUM,
    S_GAME,
    S_OVER,
    S_DONE
  } state_t;

endpackage

// File: rtl/draw_sequencer_if.sv
// Handshake bundle between the render sequencer (master) and the game/engine side (slave).
interface draw_sequencer_if
  import draw_seq_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_W       = DEF_IDX_W
);
  logic                         go;
  logic                         game_end;
  logic                         pause;
  logic [NUM_CLASSES*IDX_W-1:0] max_count;
  logic                         start_done;
  logic                         bg_done;
  logic                         hook_done;
  logic                         num_done;
  logic                         over_done;
  logic [NUM_CLASSES-1:0]       obj_done;
  logic                         start_en;
  logic                         bg_en;
  logic                         hook_en;
  logic                         num_en;
  logic                         over_en;
  logic [NUM_CLASSES-1:0]       obj_en;
  logic [IDX_W-1:0]             obj_idx;
  logic                         random_en;
  logic                         timer_en;
  logic                         timer_resetn;
  logic                         rope_resetn;
  logic                         obj_resetn;
  logic                         static_phase;
  logic                         frame_tick;
  logic                         draw_err;

  modport master (
    input  go, game_end, pause, max_count,
    input  start_done, bg_done, hook_done, num_done, over_done, obj_done,
    output start_en, bg_en, hook_en, num_en, over_en, obj_en, obj_idx,
    output random_en, timer_en, timer_resetn, rope_resetn, obj_resetn,
    output static_phase, frame_tick, draw_err
  );

  modport slave (
    output go, game_end, pause, max_count,
    output start_done, bg_done, hook_done, num_done, over_done, obj_done,
    input  start_en, bg_en, hook_en, num_en, over_en, obj_en, obj_idx,
    input  random_en, timer_en, timer_resetn, rope_resetn, obj_resetn,
    input  static_phase, frame_tick, draw_err
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and pulses frame_tick on the last count.
module frame_tick_gen
  import draw_seq_pkg::*;
#(
  parameter int FRAME_DIV = DEF_FRAME_DIV
) (
  input  logic clk,
  input  logic resetn,
  output logic frame_tick
);
  localparam int CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign frame_tick = (cnt_q == LAST);

endmodule

// File: rtl/draw_sequencer.sv
// Render sequencer: walks splash, background, per-class objects, hook, score and game-over engines.
// Optional per-phase draw watchdog enabled by defining DRAW_SEQ_TIMEOUT_EN.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int FRAME_DIV   = DEF_FRAME_DIV,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetn,
  draw_sequencer_if.master  bus
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  state_t                 state_q, state_d;
  logic [CLS_W-1:0]       cls_q, cls_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       cur_max;
  logic                   done_sel, adv, wd_hit, frame_tick;

  // Outputs are registered from the next-state decode so they track the current state exactly.
  logic start_en_q, start_en_d, bg_en_q, bg_en_d, hook_en_q, hook_en_d;
  logic num_en_q, num_en_d, over_en_q, over_en_d, random_en_q, random_en_d;
  logic timer_base_q, timer_base_d, game_q, game_d, static_q, static_d;
  logic timer_resetn_q, timer_resetn_d, rope_resetn_q, rope_resetn_d;
  logic obj_resetn_q, obj_resetn_d;
  logic [NUM_CLASSES-1:0] obj_en_q, obj_en_d;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_frame_tick (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick)
  );

  assign cur_max = bus.max_count[int'(cls_q)*IDX_W +: IDX_W];

`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d, watched;

  assign watched = state_q inside {S_SPLASH_WAIT, S_BG, S_OBJ, S_HOOK, S_NUM, S_OVER};
  assign wd_hit  = watched && (wd_q == WD_LAST);

  always_comb begin
    wd_d  = (state_d != state_q) ? '0 : wd_q + 1'b1;
    err_d = err_q | (wd_hit & ~done_sel);
  end

  assign bus.draw_err = err_q;
`else
  assign wd_hit       = 1'b0;
  assign bus.draw_err = 1'b0;
`endif

  always_comb begin
    done_sel = 1'b0;
    unique case (state_q)
      S_SPLASH_WAIT: done_sel = bus.start_done;
      S_BG:          done_sel = bus.bg_done;
      S_OBJ:         done_sel = bus.obj_done[cls_q];
      S_HOOK:        done_sel = bus.hook_done;
      S_NUM:         done_sel = bus.num_done;
      S_OVER:        done_sel = bus.over_done;
      default:       done_sel = 1'b0;
    endcase
    adv = done_sel | wd_hit;

    state_d = state_q;
    cls_d   = cls_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_START:       state_d = S_SPLASH;
      S_SPLASH:      state_d = S_SPLASH_WAIT;
      S_SPLASH_WAIT: if (adv) state_d = S_GEN_XY;
      S_GEN_XY: if (bus.go) begin
        state_d = S_BG;
        cls_d   = '0;
        idx_d   = '0;
      end
      S_BG:          if (adv) state_d = S_OBJ_SEL;
      // Empty or exhausted classes advance one class per cycle.
      S_OBJ_SEL: begin
        if (idx_q < cur_max)        state_d = S_OBJ;
        else if (cls_q == LAST_CLS) state_d = S_HOOK;
        else begin
          cls_d = cls_q + 1'b1;
          idx_d = '0;
        end
      end
      S_OBJ: if (adv) begin
        idx_d   = idx_q + 1'b1;
        state_d = S_OBJ_SEL;
      end
      S_HOOK:        if (adv) state_d = S_NUM;
      S_NUM:         if (adv) state_d = S_GAME;
      // game_end wins over a redraw tick and is honoured while paused.
      S_GAME: begin
        if (bus.game_end) state_d = S_OVER;
        else if (frame_tick && !bus.pause) begin
          state_d = S_BG;
          cls_d   = '0;
          idx_d   = '0;
        end
      end
      S_OVER:        if (adv) state_d = S_DONE;
      S_DONE:        if (bus.go) state_d = S_GEN_XY;
      default:       state_d = S_START;
    endcase

    start_en_d     = state_d inside {S_SPLASH, S_SPLASH_WAIT};
    rope_resetn_d  = !(state_d inside {S_SPLASH, S_SPLASH_WAIT, S_GEN_XY});
    random_en_d    = (state_d == S_GEN_XY);
    timer_resetn_d = (state_d != S_GEN_XY);
    bg_en_d        = (state_d == S_BG);
    obj_en_d       = (state_d == S_OBJ) ? (NUM_CLASSES'(1) << cls_d) : '0;
    hook_en_d      = (state_d == S_HOOK);
    num_en_d       = (state_d == S_NUM);
    over_en_d      = (state_d == S_OVER);
    game_d         = (state_d == S_GAME);
    obj_resetn_d   = (state_d != S_GAME);
    timer_base_d   = state_d inside {S_BG, S_OBJ_SEL, S_OBJ, S_HOOK, S_NUM, S_OVER};
    static_d       = state_d inside {S_BG, S_OBJ_SEL, S_OBJ};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_START;
      cls_q          <= '0;
      idx_q          <= '0;
      start_en_q     <= 1'b0;
      bg_en_q        <= 1'b0;
      hook_en_q      <= 1'b0;
      num_en_q       <= 1'b0;
      over_en_q      <= 1'b0;
      obj_en_q       <= '0;
      random_en_q    <= 1'b0;
      timer_base_q   <= 1'b0;
      game_q         <= 1'b0;
      static_q       <= 1'b0;
      timer_resetn_q <= 1'b1;
      rope_resetn_q  <= 1'b1;
      obj_resetn_q   <= 1'b1;
`ifdef DRAW_SEQ_TIMEOUT_EN
      wd_q           <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cls_q          <= cls_d;
      idx_q          <= idx_d;
      start_en_q     <= start_en_d;
      bg_en_q        <= bg_en_d;
      hook_en_q      <= hook_en_d;
      num_en_q       <= num_en_d;
      over_en_q      <= over_en_d;
      obj_en_q       <= obj_en_d;
      random_en_q    <= random_en_d;
      timer_base_q   <= timer_base_d;
      game_q         <= game_d;
      static_q       <= static_d;
      timer_resetn_q <= timer_resetn_d;
      rope_resetn_q  <= rope_resetn_d;
      obj_resetn_q   <= obj_resetn_d;
`ifdef DRAW_SEQ_TIMEOUT_EN
      wd_q           <= wd_d;
      err_q          <= err_d;
`endif
    end
  end

  assign bus.start_en     = start_en_q;
  assign bus.bg_en        = bg_en_q;
  assign bus.hook_en      = hook_en_q;
  assign bus.num_en       = num_en_q;
  assign bus.over_en      = over_en_q;
  assign bus.obj_en       = obj_en_q;
  assign bus.obj_idx      = idx_q;
  assign bus.random_en    = random_en_q;
  // Gameplay timer freezes with pause only while the game screen is live.
  assign bus.timer_en     = game_q ? !bus.pause : timer_base_q;
  assign bus.timer_resetn = timer_resetn_q;
  assign bus.rope_resetn  = rope_resetn_q;
  assign bus.obj_resetn   = obj_resetn_q;
  assign bus.static_phase = static_q;
  assign bus.frame_tick   = frame_tick;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer; object draws are checked against a scoreboard queue.
module tb_draw_sequencer;
  import draw_seq_pkg::*;

  localparam int NC = 3;
  localparam int IW = 5;
  localparam int FD = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  draw_sequencer_if #(.NUM_CLASSES(NC), .IDX_W(IW)) bus ();

  draw_sequencer #(
    .NUM_CLASSES (NC),
    .IDX_W       (IW),
    .FRAME_DIV   (FD),
    .TIMEOUT     (TO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [NC-1:0] en;
    logic [IW-1:0] idx;
    int            gap;
  } obj_exp_t;

  obj_exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the expected object sequence (enable, index, OBJ_SEL cycles before it), then drives
  // the frame from BG until HOOK, or until the (stop_c, stop_i) object is reached.
  task automatic run_frame(input int m0, input int m1, input int m2,
                           input int stop_c, input int stop_i);
    int       m[3];
    int       pending;
    int       gap;
    bit       stop;
    obj_exp_t e;
    m = '{m0, m1, m2};
    bus.max_count = {IW'(m2), IW'(m1), IW'(m0)};
    sb.delete();
    pending = 0;
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < m[c]; i++) begin
        pending++;
        e.en  = NC'(1) << c;
        e.idx = IW'(i);
        e.gap = pending;
        sb.push_back(e);
        pending = 0;
      end
      pending++;
    end
    bus.bg_done = 1'b1;
    step();
    bus.bg_done = 1'b0;
    gap  = 0;
    stop = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus.obj_en != '0) begin
        if (sb.size() == 0) begin
          check("obj_unexpected", 32'(bus.obj_en), 0);
          break;
        end
        e = sb.pop_front();
        $display("obj draw: obj_en=%b obj_idx=%0d gap=%0d", bus.obj_en, bus.obj_idx, gap);
        check("obj_en", 32'(bus.obj_en), 32'(e.en));
        check("obj_idx", 32'(bus.obj_idx), 32'(e.idx));
        check("obj_sel_gap", gap, e.gap);
        check("obj_static", 32'(bus.static_phase), 1);
        if (stop_c >= 0 && int'(e.idx) == stop_i && e.en == (NC'(1) << stop_c)) begin
          stop = 1'b1;
          break;
        end
        bus.obj_done = ~bus.obj_en;
        step();
        check("obj_other_done_ignored", 32'(bus.obj_en), 32'(e.en));
        check("obj_idx_stable", 32'(bus.obj_idx), 32'(e.idx));
        bus.obj_done = bus.obj_en;
        step();
        bus.obj_done = '0;
        gap = 0;
      end else if (bus.hook_en === 1'b1) begin
        break;
      end else begin
        gap++;
        step();
      end
    end
    if (!stop) begin
      check("frame_reached_hook", 32'(bus.hook_en), 1);
      check("hook_sel_gap", gap, pending);
      check("sb_drained", sb.size(), 0);
      check("hook_not_static", 32'(bus.static_phase), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    bit ticked;
    int t0, t1, cnt;
    bus.go = 1'b0; bus.game_end = 1'b0; bus.pause = 1'b0; bus.max_count = '0;
    bus.start_done = 1'b0; bus.bg_done = 1'b0; bus.hook_done = 1'b0;
    bus.num_done = 1'b0; bus.over_done = 1'b0; bus.obj_done = '0;

    #3 resetn = 1'b0;
    repeat (3) step();
    $display("reset state check");
    check("rst_start_en", 32'(bus.start_en), 0);
    check("rst_obj_en", 32'(bus.obj_en), 0);
    check("rst_obj_idx", 32'(bus.obj_idx), 0);
    check("rst_rope_resetn", 32'(bus.rope_resetn), 1);
    check("rst_timer_resetn", 32'(bus.timer_resetn), 1);
    check("rst_obj_resetn", 32'(bus.obj_resetn), 1);
    check("rst_draw_err", 32'(bus.draw_err), 0);
    check("rst_frame_tick", 32'(bus.frame_tick), 0);
    resetn = 1'b1;

    step();
    $display("splash entry");
    check("splash_start_en", 32'(bus.start_en), 1);
    check("splash_rope_resetn", 32'(bus.rope_resetn), 0);
    step();
    check("splash_wait_start_en", 32'(bus.start_en), 1);
    bus.start_done = 1'b1;
    step();
    bus.start_done = 1'b0;
    $display("gen_xy entry");
    check("genxy_random_en", 32'(bus.random_en), 1);
    check("genxy_timer_resetn", 32'(bus.timer_resetn), 0);
    check("genxy_start_en", 32'(bus.start_en), 0);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    $display("bg entry");
    check("bg_en", 32'(bus.bg_en), 1);
    check("bg_static", 32'(bus.static_phase), 1);
    check("bg_timer_en", 32'(bus.timer_en), 1);

    run_frame(3, 0, 2, -1, -1);

    bus.hook_done = 1'b1;
    step();
    bus.hook_done = 1'b0;
    check("num_en", 32'(bus.num_en), 1);
    bus.pause = 1'b1;
    bus.num_done = 1'b1;
    step();
    bus.num_done = 1'b0;
    $display("game entry paused");
    check("game_obj_resetn", 32'(bus.obj_resetn), 0);
    check("game_pause_timer_en", 32'(bus.timer_en), 0);

    bus.bg_done = 1'b1;
    step();
    bus.bg_done = 1'b0;
    check("stray_bg_done_bg_en", 32'(bus.bg_en), 0);
    check("stray_bg_done_in_game", 32'(bus.obj_resetn), 0);

    t0 = -1; t1 = -1;
    for (int i = 0; i < 12; i++) begin
      if (bus.frame_tick === 1'b1) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
      step();
    end
    $display("paused frame ticks at %0d and %0d", t0, t1);
    check("tick_period", t1 - t0, FD);
    check("paused_stays_game", 32'(bus.obj_resetn), 0);
    check("paused_timer_en", 32'(bus.timer_en), 0);

    bus.pause = 1'b0;
    #1;
    check("unpaused_timer_en", 32'(bus.timer_en), 1);
    ticked = 1'b0;
    for (int i = 0; i < 2 * FD; i++) begin
      ticked = bus.frame_tick;
      step();
      if (ticked) break;
    end
    $display("redraw after unpause");
    check("resume_tick_seen", 32'(ticked), 1);
    check("resume_bg_en", 32'(bus.bg_en), 1);

    run_frame(0, 0, 0, -1, -1);
    bus.hook_done = 1'b1;
    step();
    bus.hook_done = 1'b0;
    bus.pause = 1'b1;
    bus.num_done = 1'b1;
    step();
    bus.num_done = 1'b0;
    check("game2_obj_resetn", 32'(bus.obj_resetn), 0);

    ticked = 1'b0;
    for (int i = 0; i < 2 * FD; i++) begin
      if (bus.frame_tick === 1'b1) begin
        ticked = 1'b1;
        break;
      end
      step();
    end
    check("end_tick_seen", 32'(ticked), 1);
    bus.pause = 1'b0;
    bus.game_end = 1'b1;
    step();
    bus.game_end = 1'b0;
    $display("game_end with frame_tick");
    check("over_en", 32'(bus.over_en), 1);
    check("over_not_bg", 32'(bus.bg_en), 0);
    bus.over_done = 1'b1;
    step();
    bus.over_done = 1'b0;
    check("done_over_en", 32'(bus.over_en), 0);
    check("done_obj_resetn", 32'(bus.obj_resetn), 1);
    check("done_random_en", 32'(bus.random_en), 0);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    $display("restart to gen_xy");
    check("restart_random_en", 32'(bus.random_en), 1);

    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    run_frame(0, 3, 1, 1, 2);
    #1 resetn = 1'b0;
    #1;
    $display("async reset mid-object");
    check("midrst_obj_en", 32'(bus.obj_en), 0);
    check("midrst_obj_idx", 32'(bus.obj_idx), 0);
    check("midrst_static", 32'(bus.static_phase), 0);
    check("midrst_rope_resetn", 32'(bus.rope_resetn), 1);
    check("midrst_obj_resetn", 32'(bus.obj_resetn), 1);
    check("midrst_timer_resetn", 32'(bus.timer_resetn), 1);
    step();
    check("midrst_hold_start_en", 32'(bus.start_en), 0);
    resetn = 1'b1;
    step();
    check("post_rst_splash", 32'(bus.start_en), 1);
    check("post_rst_draw_err", 32'(bus.draw_err), 0);

`ifdef DRAW_SEQ_TIMEOUT_EN
    step();
    bus.start_done = 1'b1;
    step();
    bus.start_done = 1'b0;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    run_frame(0, 0, 0, -1, -1);
    check("wd_pre_err", 32'(bus.draw_err), 0);
    cnt = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      if (bus.hook_en !== 1'b1) break;
      cnt++;
      step();
    end
    $display("hook watchdog after %0d cycles", cnt);
    check("wd_hook_cycles", cnt, TO);
    check("wd_num_en", 32'(bus.num_en), 1);
    check("wd_draw_err", 32'(bus.draw_err), 1);
    repeat (3) step();
    check("wd_err_sticky", 32'(bus.draw_err), 1);
    resetn = 1'b0;
    #1;
    check("wd_err_cleared", 32'(bus.draw_err), 0);
    resetn = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Parametrised render sequencer for the Gold Miner display pipeline. It cycles the VGA drawing engines through splash, background, N classes of mine objects, hook, score overlay and game-over screen. It issues level enables to each engine and steps per-instance object indices internally. It paces gameplay redraws from an internal frame divider, with pause support and an optional per-phase draw watchdog.

## Interface
- NUM_CLASSES, 3: number of object classes (e.g. gold, stone, diamond); ≥1.
- IDX_W, 5: instance index width; per-class max count width.
- FRAME_DIV, 833334: clk cycles per frame tick; ≥2.
- TIMEOUT, 65535: watchdog limit in cycles, used only with the macro.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- go  in  1  player start/restart.
- game_end  in  1  level over, from game logic.
- pause  in  1  freeze gameplay.
- max_count  in  NUM_CLASSES*IDX_W  instances per class; class c at [c*IDX_W +: IDX_W].
- start_done, bg_done, hook_done, num_done, over_done  in  1 each  engine done strobes.
- obj_done  in  NUM_CLASSES  per-class object engine done.
- start_en, bg_en, hook_en, num_en, over_en  out  1 each  engine enables.
- obj_en  out  NUM_CLASSES  one-hot object enable.
- obj_idx  out  IDX_W  instance being drawn.
- random_en  out  1  position generator enable.
- timer_en  out  1  game timer count enable.
- timer_resetn  out  1  active-low game timer clear.
- rope_resetn  out  1  active-low rope/hook clear.
- obj_resetn  out  1  active-low object-state clear.
- static_phase  out  1  high while static layers (background/objects) draw.
- frame_tick  out  1  one-cycle frame pulse.
- draw_err  out  1  sticky watchdog flag.

## Operation
- States: START → SPLASH → SPLASH_WAIT → GEN_XY → BG → OBJ_SEL ⇄ OBJ → HOOK → NUM → GAME → (BG | OVER) ; OVER → DONE → GEN_XY.
- START: unconditional → SPLASH. SPLASH: start_en=1, rope_resetn=0, one cycle. SPLASH_WAIT: same outputs; start_done → GEN_XY.
- GEN_XY: random_en=1, timer_resetn=0, rope_resetn=0; go → BG.
- BG: bg_en=1, timer_en=1, static_phase=1; on entry class c:=0, obj_idx:=0; bg_done → OBJ_SEL.
- OBJ_SEL (one cycle, static_phase=1, timer_en=1) has three outcomes:
  - obj_idx < max[c] → OBJ.
  - Otherwise, if c=NUM_CLASSES-1 → HOOK.
  - Otherwise c++, obj_idx:=0, stay.
  - max[c]=0 skips the class in one cycle.
- OBJ: obj_en[c]=1, timer_en=1, static_phase=1; obj_done[c] → obj_idx++, → OBJ_SEL. obj_done bits ≠ c are ignored.
- HOOK: hook_en=1, timer_en=1; hook_done → NUM. NUM: num_en=1, timer_en=1; num_done → GAME.
- GAME: obj_resetn=0 and timer_en=!pause. Exits, in priority order:
  - game_end → OVER (honoured even when paused).
  - frame_tick && !pause → BG.
- OVER: over_en=1, timer_en=1; over_done → DONE. DONE: go → GEN_XY (fresh positions).
- Defaults (all states unless listed): enables 0, active-low outputs 1, static_phase 0.
- Frame divider: free-running 0..FRAME_DIV-1. frame_tick=1 when it equals FRAME_DIV-1, then wraps to 0.

## Timing
- Moore outputs decode current state only. obj_en and obj_idx are stable throughout OBJ.
- A done strobe sampled high while its enable is high leaves the state on the next clk edge. The enable drops that edge. A done with its enable low is ignored.
- Per-object cost: OBJ cycles + 1 OBJ_SEL cycle. Empty-class skip: 1 cycle.
- Simultaneous game_end and frame_tick in GAME → OVER.
- Reset (async, any time, including mid-draw):
  - state=START, counter=0, obj_idx=0, c=0, draw_err=0.
  - All enables 0; timer_resetn, rope_resetn, obj_resetn = 1.
- obj_idx is IDX_W bits and never exceeds max[c]; it cannot wrap.

## Configuration
- DRAW_SEQ_TIMEOUT_EN defined:
  - A cycle counter clears on entry to every *_WAIT/BG/OBJ/HOOK/NUM/OVER state.
  - When it reaches TIMEOUT with done still low, the FSM advances as if done, and draw_err is set.
  - draw_err clears only on reset.
- Undefined: states wait indefinitely; draw_err tied 0; no counter logic.

## Structure
- Shared package draw_seq_pkg:
  - state enum and its width constant.
  - Default parameter constants for NUM_CLASSES, IDX_W and FRAME_DIV.
- Sub-module frame_tick_gen (FRAME_DIV param; clk, resetn → frame_tick).
- Everything else is in one module.

## Test plan
- Reset mid-OBJ (c=1, obj_idx=2) → START next cycle, all enables 0, obj_idx=0, resetn-style outputs 1.
- max_count={3,0,2} (classes 0,1,2): full frame yields obj_en=001 for idx 0,1,2; class 1 skipped in 1 cycle; obj_en=100 for idx 0,1; then HOOK.
- Done strobe while its enable is low (bg_done in GAME) → no transition.
- FRAME_DIV=4, pause held in GAME → frame_tick every 4 cycles, state stays GAME, timer_en=0. Releasing pause → BG on next tick.
- game_end and frame_tick in the same cycle → OVER; over_done → DONE; go → GEN_XY with random_en=1.
- With DRAW_SEQ_TIMEOUT_EN and TIMEOUT=8, hook_done never arrives → NUM after 8 HOOK cycles, draw_err=1 until reset.
